seek_ce: RTL and testbench
==========================

Name: seek_ce

Overview:
- Normalisation stage that sits directly upstream of the f-computation stage.
- Accepts one unsigned operand per start pulse and left-shifts it one bit per cycle until the MSB is set.
- Emits the normalised mantissa c and exponent/flag word e, with a one-cycle valid pulse that drives the downstream en input.
- Iterative design: one operand in flight at a time.

Parameters:
- DW, `Datawidth (16), width of operand and of c.
- EW, 14, width of e; bit EW-1 is the zero flag, bits EW-2:0 are the shift count.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- x  input  DW  unsigned operand, sampled on an accepted start
- start  input  1  request; accepted only when busy=0
- flush  input  1  synchronous abort of the operation in flight
- c  output  DW  normalised mantissa (registered, held between results)
- e  output  EW  {zero_flag, shift_count} (registered, held between results)
- out_en  output  1  one-cycle result-valid pulse; connects to the downstream en
- busy  output  1  high while an operand is in flight

Behaviour:
- reset=0 (async, any state): state=IDLE; shift register, counter, c, e, out_en and busy all go to 0.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 and x!=0: load sreg<=x, cnt<=0, state->SHIFT.
  - start=1 and x==0: on that edge c<=0, e<={1'b1, (EW-1)'b0}, out_en<=1; stay in IDLE.
  - start=0: out_en<=0.
- SHIFT, each edge:
  - sreg[DW-1]==1: c<=sreg, e<={1'b0, cnt}, out_en<=1, state->IDLE.
  - Otherwise: sreg<=sreg<<1 (zero fill), cnt<=cnt+1, out_en<=0.
- Latency: the start edge is edge 0; out_en is high after edge lz+1, where lz = leading-zero count of x (0..DW-1). Zero input gives out_en after edge 0.
- Worst case: DW cycles (x=1).
- busy = (state==SHIFT), registered with the state.
- out_en is exactly one cycle wide. c and e keep their last result until the next result overwrites them; they never change when out_en=0.
- start while busy=1: ignored, operand dropped, no error flag. Upstream must wait for busy=0.
- Back-to-back: a start in the cycle out_en is high (state IDLE) is accepted.
- flush=1 in SHIFT: state->IDLE, out_en stays 0, c/e unchanged.
- flush has priority over both the SHIFT completion test and start; flush and start in the same cycle means start is ignored.
- Counter width: EW-1 bits (13), well above log2(DW); the counter never wraps for DW<=8192.
- Asynchronous reset mid-SHIFT: the operation is discarded and no out_en is produced.

Decomposition:
- Shared define file holds Datawidth (existing) plus EW=14 and ZFLAG_BIT=13, so downstream reads e[ZFLAG_BIT] and e[EW-2:0] by name.
- State encoding is a local 1-bit constant pair.
- No sub-module: the shift/count datapath is small enough to stay inline. An optional parallel leading-zero counter is deliberately not used; the serial form is the decided architecture.

Test Plan:
- x=16'h8000, start 1 cycle -> out_en after edge 1, c=16'h8000, e=14'h0000, busy high for exactly 1 cycle.
- x=16'h1234 -> out_en after edge 4, c=16'h91A0, e=14'h0003.
- x=16'h0001 -> out_en after edge 16, c=16'h8000, e=14'h000F; start pulses with x=16'hFFFF during busy are ignored and no extra out_en appears.
- x=16'h0000 -> out_en after edge 0, c=16'h0000, e=14'h2000, busy never asserts. Then x=16'h4000 started in the out_en cycle -> c=16'h8000, e=14'h0001 two cycles later.
- x=16'h0010, flush asserted on edge 5 -> no out_en, busy drops after edge 5, c/e retain previous values. Next start with x=16'h0100 -> e=14'h0007.
- x=16'h0004, reset pulled low mid-SHIFT -> c, e, out_en, busy read 0 immediately (asynchronous). After release, start with x=16'h0002 -> e=14'h000E, c=16'h8000.

Source files
------------

// File: rtl/seek_ce_pkg.sv
// Shared widths for the normalisation stage and its downstream f-computation consumer.
// Downstream reads the zero flag as e[ZFLAG_BIT] and the shift count as e[E_WIDTH-2:0].
package seek_ce_pkg;
    localparam int DATAWIDTH = 16;
    localparam int E_WIDTH   = 14;
    localparam int ZFLAG_BIT = E_WIDTH - 1;
endpackage

// File: rtl/seek_ce.sv
// Serial normaliser: shifts the operand left one bit per cycle until its MSB is set,
// then reports the mantissa c and {zero_flag, shift_count} on e with a one-cycle out_en.
module seek_ce
    import seek_ce_pkg::*;
#(
    parameter int DW = DATAWIDTH,
    parameter int EW = E_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] x,
    input  logic          start,
    input  logic          flush,
    output logic [DW-1:0] c,
    output logic [EW-1:0] e,
    output logic          out_en,
    output logic          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] sreg;
    logic [DW-1:0] sreg_next;
    logic [EW-2:0] cnt;
    logic [EW-2:0] cnt_next;
    logic [DW-1:0] c_next;
    logic [EW-1:0] e_next;
    logic          out_en_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            c      <= '0;
            e      <= '0;
            out_en <= 1'b0;
        end else begin
            state  <= state_next;
            sreg   <= sreg_next;
            cnt    <= cnt_next;
            c      <= c_next;
            e      <= e_next;
            out_en <= out_en_next;
        end
    end

    // flush outranks both the completion test and a new start.
    always_comb begin
        state_next  = state;
        sreg_next   = sreg;
        cnt_next    = cnt;
        c_next      = c;
        e_next      = e;
        out_en_next = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (x != '0) begin
                        sreg_next  = x;
                        cnt_next   = '0;
                        state_next = SHIFT;
                    end else begin
                        c_next      = '0;
                        e_next      = {1'b1, {(EW-1){1'b0}}};
                        out_en_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (sreg[DW-1]) begin
                    c_next      = sreg;
                    e_next      = {1'b0, cnt};
                    out_en_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    sreg_next = sreg << 1;
                    cnt_next  = cnt + {{(EW-2){1'b0}}, 1'b1};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_seek_ce.sv
// Self-checking bench for seek_ce: directed plan cases plus randomized operands
// compared against a leading-zero reference model.
module tb_seek_ce;

    localparam int DW = 16;
    localparam int EW = 14;

    logic          clk;
    logic          reset;
    logic [DW-1:0] x;
    logic          start;
    logic          flush;
    logic [DW-1:0] c;
    logic [EW-1:0] e;
    logic          out_en;
    logic          busy;

    int errors;
    int checks;

    seek_ce #(.DW(DW), .EW(EW)) dut (
        .clk    (clk),
        .reset  (reset),
        .x      (x),
        .start  (start),
        .flush  (flush),
        .c      (c),
        .e      (e),
        .out_en (out_en),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mantissa is x with its leading zeros shifted out, exponent is their count.
    function automatic void ref_norm(input logic [DW-1:0] xv, output logic [DW-1:0] ec,
                                     output logic [EW-1:0] ee, output int lat);
        int lz;
        lz = DW;
        for (int i = DW - 1; i >= 0; i--) begin
            if (xv[i]) begin
                lz = DW - 1 - i;
                break;
            end
        end
        if (lz == DW) begin
            ec  = '0;
            ee  = 14'h2000;
            lat = 0;
        end else begin
            ec  = xv << lz;
            ee  = EW'(lz);
            lat = lz + 1;
        end
    endfunction

    // Starts one operation and follows it to its out_en; returns just after the result edge.
    task automatic do_op(input logic [DW-1:0] xv, input string name, input bit now, input bit spam);
        logic [DW-1:0] ec;
        logic [EW-1:0] ee;
        int lat;
        int edges;
        int busy_cnt;
        ref_norm(xv, ec, ee, lat);
        if (!now) @(negedge clk);
        x     = xv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        while (!out_en && edges < DW + 4) begin
            if (busy) busy_cnt++;
            if (spam) begin
                start = ~start;
                x     = 16'hFFFF;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        checks++;
        if (out_en !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_en=%b after %0d edges, required pulse after edge %0d", name, out_en, edges, lat);
            return;
        end
        checks++;
        if (edges !== lat) begin
            errors++;
            $display("FAIL %s latency: got edge %0d, required edge %0d", name, edges, lat);
        end
        checks++;
        if (c !== ec) begin
            errors++;
            $display("FAIL %s c: got %h, required %h", name, c, ec);
        end
        checks++;
        if (e !== ee) begin
            errors++;
            $display("FAIL %s e: got %h, required %h", name, e, ee);
        end
        checks++;
        if (busy_cnt !== lat || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: %0d busy cycles (now %b), required %0d cycles then 0", name, busy_cnt, busy, lat);
        end
    endtask

    // Idles for n cycles; out_en must stay low and c/e must hold.
    task automatic check_quiet(input int n, input string name);
        logic [DW-1:0] hc;
        logic [EW-1:0] he;
        int bad;
        hc  = c;
        he  = e;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (out_en !== 1'b0 || busy !== 1'b0 || c !== hc || e !== he) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d cycles with activity (out_en=%b busy=%b c=%h e=%h), required none, c=%h e=%h",
                     name, bad, out_en, busy, c, e, hc, he);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        x     = '0;
        start = 1'b0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (c !== '0 || e !== '0 || out_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: c=%h e=%h out_en=%b busy=%b, required all 0", c, e, out_en, busy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        do_op(16'h8000, "msb_set", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (out_en !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: out_en=%b one cycle after result, required 0", out_en);
        end
        do_op(16'h1234, "x1234", 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_op(16'h0001, "x0001_spam", 1'b0, 1'b1);
        check_quiet(20, "after_spam");
    endtask

    task automatic test_zero_back_to_back();
        do_op(16'h0000, "zero", 1'b0, 1'b0);
        do_op(16'h4000, "back_to_back", 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [DW-1:0] hc;
        logic [EW-1:0] he;
        hc = c;
        he = e;
        @(negedge clk);
        x     = 16'h0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_en !== 1'b0 || c !== hc || e !== he) begin
            errors++;
            $display("FAIL flush: busy=%b out_en=%b c=%h e=%h, required 0 0 %h %h", busy, out_en, c, e, hc, he);
        end
        check_quiet(20, "after_flush");
        @(negedge clk);
        x     = 16'h0003;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_start: busy=%b out_en=%b, required 0 0", busy, out_en);
        end
        do_op(16'h0100, "after_flush_op", 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        x     = 16'h0004;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (c !== '0 || e !== '0 || out_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: c=%h e=%h out_en=%b busy=%b, required all 0", c, e, out_en, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        check_quiet(8, "after_async_reset");
        do_op(16'h0002, "after_reset_op", 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [DW-1:0] xv;
        for (int n = 0; n < 40; n++) begin
            xv = DW'($urandom >> $urandom_range(16, 32));
            do_op(xv, $sformatf("rand%0d_%h", n, xv), 1'b0, 1'b0);
            check_quiet($urandom_range(1, 4), $sformatf("rand%0d_hold", n));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        $display("[TB] seek_ce bench start");
        test_reset();
        test_basic();
        test_busy_ignore();
        test_zero_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
